// File: rtl/commit_pkg.sv
// Shared definitions for the commit report path: width constants and the
// retired-instruction record carried from writeback to the difftest port.
package commit_pkg;

  localparam int XLEN     = 64;
  localparam int INST_W   = 32;
  localparam int CSR_ID_W = 12;

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [INST_W-1:0]   inst;
    logic                is_mmio;
    logic [CSR_ID_W-1:0] rcsr_id;
  } commit_rec_t;

endpackage

// File: rtl/commit_fifo.sv
// Record storage for the commit report queue. Power-of-two depth, so the
// pointers wrap on their own. The head entry is read straight from the
// storage flops and forced to zero while the queue is empty.
module commit_fifo
  import commit_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type rec_t = commit_rec_t
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  rec_t wdata,
  output rec_t rdata,
  output logic full,
  output logic empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  rec_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy update; push and pop together leave count alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Record storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (do_push && !reset) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/commit_report_queue.sv
// Commit report queue: buffers retired-instruction records from writeback
// and presents them in program order to the difftest side, counting
// delivered records. Define COMMIT_WATCHDOG_EN to build the hang watchdog;
// without it hang is tied low and no watchdog counter exists.
module commit_report_queue
  import commit_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [INST_W-1:0]   in_inst,
  input  logic                in_is_mmio,
  input  logic [CSR_ID_W-1:0] in_rcsr_id,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [INST_W-1:0]   out_inst,
  output logic                out_is_mmio,
  output logic [CSR_ID_W-1:0] out_rcsr_id,
  output logic [63:0]         commit_cnt,
  output logic                hang
);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || WDOG_CYCLES < 1)
  begin : g_param_check
    $error("commit_report_queue: illegal DEPTH or WDOG_CYCLES");
  end

  commit_rec_t in_rec;
  commit_rec_t head_rec;
  logic        fifo_full;
  logic        fifo_empty;
  logic        in_fire;
  logic        out_fire;

  assign in_rec = '{pc: in_pc, inst: in_inst, is_mmio: in_is_mmio, rcsr_id: in_rcsr_id};

  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  assign out_pc      = head_rec.pc;
  assign out_inst    = head_rec.inst;
  assign out_is_mmio = head_rec.is_mmio;
  assign out_rcsr_id = head_rec.rcsr_id;

  commit_fifo #(
    .DEPTH (DEPTH),
    .rec_t (commit_rec_t)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (in_fire),
    .pop   (out_fire),
    .wdata (in_rec),
    .rdata (head_rec),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Delivered-record counter, wraps naturally at 2^64.
  always_ff @(posedge clock) begin
    if (reset)         commit_cnt <= '0;
    else if (out_fire) commit_cnt <= commit_cnt + 64'd1;
  end

`ifdef COMMIT_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_CYCLES);

  logic [WDOG_W-1:0] wdog_cnt;
  logic              hang_q;

  // Idle-cycle count, saturating; hang latches on the cycle the count
  // reaches the limit and stays up until reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wdog_cnt <= '0;
      hang_q   <= 1'b0;
    end else if (out_fire) begin
      wdog_cnt <= '0;
    end else begin
      if (wdog_cnt != WDOG_MAX)            wdog_cnt <= wdog_cnt + 1'b1;
      if (wdog_cnt >= WDOG_MAX - 1'b1)     hang_q   <= 1'b1;
    end
  end

  assign hang = hang_q;
`else
  assign hang = 1'b0;
`endif

endmodule

// File: tb/tb_commit_report_queue.sv
// Directed bench for commit_report_queue (DEPTH=4, WDOG_CYCLES=16).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_commit_report_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_inst;
  logic        in_is_mmio;
  logic [11:0] in_rcsr_id;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_is_mmio;
  logic [11:0] out_rcsr_id;
  logic [63:0] commit_cnt;
  logic        hang;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  commit_report_queue #(.DEPTH(4), .WDOG_CYCLES(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_inst     (in_inst),
    .in_is_mmio  (in_is_mmio),
    .in_rcsr_id  (in_rcsr_id),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .out_is_mmio (out_is_mmio),
    .out_rcsr_id (out_rcsr_id),
    .commit_cnt  (commit_cnt),
    .hang        (hang)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                       input logic mmio, input logic [11:0] csr);
    in_valid   = v;
    in_pc      = pc;
    in_inst    = inst;
    in_is_mmio = mmio;
    in_rcsr_id = csr;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 64'h0, 32'h0, 1'b0, 12'h0);
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (commit_cnt !== 64'd0) begin errors++; $display("FAIL reset_commit_cnt got=%0d exp=0", commit_cnt); end
    checks++;
    if (hang !== 1'b0) begin errors++; $display("FAIL reset_hang got=%b exp=0", hang); end
    checks++;
    if (out_pc !== 64'h0 || out_inst !== 32'h0) begin
      errors++; $display("FAIL reset_out_fields got pc=%h inst=%h exp 0", out_pc, out_inst);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1'b1, 64'h0000_0000_8000_0000, 32'h0000_0013, 1'b0, 12'h000);
    step();
    drive(1'b0, 64'h0, 32'h0, 1'b0, 12'h0);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    checks++;
    if (out_pc !== 64'h8000_0000 || out_inst !== 32'h0000_0013) begin
      errors++; $display("FAIL single_fields got pc=%h inst=%h exp pc=80000000 inst=00000013", out_pc, out_inst);
    end
    step();
    checks++;
    if (commit_cnt !== 64'd1) begin errors++; $display("FAIL single_commit_cnt got=%0d exp=1", commit_cnt); end
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 64'h0) begin
      errors++; $display("FAIL single_drain got valid=%b pc=%h exp 0/0", out_valid, out_pc);
    end
  endtask

  task automatic test_fill_and_full_pop();
    logic [63:0] exp_pc;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready_%0d got=%b exp=1", i, in_ready); end
      drive(1'b1, 64'h1000 + 64'(4 * i), 32'h100 + 32'(i), 1'b0, 12'h0);
      step();
    end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    drive(1'b1, 64'h1010, 32'h104, 1'b0, 12'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 64'h1000 || out_inst !== 32'h100) begin
        errors++;
        $display("FAIL stall_hold_%0d got ready=%b valid=%b pc=%h inst=%h exp 0/1/1000/100",
                 i, in_ready, out_valid, out_pc, out_inst);
      end
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_pc !== 64'h1004 || in_ready !== 1'b1) begin
      errors++; $display("FAIL full_pop_only got pc=%h ready=%b exp 1004/1", out_pc, in_ready);
    end
    step();
    drive(1'b0, 64'h0, 32'h0, 1'b0, 12'h0);
    exp_pc = 64'h1008;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc) begin
        errors++; $display("FAIL order_%0d got valid=%b pc=%h exp 1/%h", i, out_valid, out_pc, exp_pc);
      end
      exp_pc = exp_pc + 64'd4;
      step();
    end
    checks++;
    if (out_valid !== 1'b0 || commit_cnt !== 64'd6) begin
      errors++; $display("FAIL fill_drain got valid=%b cnt=%0d exp 0/6", out_valid, commit_cnt);
    end
  endtask

  task automatic test_mmio_csr();
    out_ready = 1'b0;
    drive(1'b1, 64'h2000, 32'h1234_5073, 1'b1, 12'hB00);
    step();
    drive(1'b0, 64'h0, 32'h0, 1'b0, 12'h0);
    checks++;
    if (out_is_mmio !== 1'b1 || out_rcsr_id !== 12'hB00 || out_inst !== 32'h1234_5073) begin
      errors++; $display("FAIL mmio_fields got mmio=%b csr=%h inst=%h exp 1/b00/12345073",
                         out_is_mmio, out_rcsr_id, out_inst);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (commit_cnt !== 64'd7 || out_is_mmio !== 1'b0 || out_rcsr_id !== 12'h0) begin
      errors++; $display("FAIL mmio_drain got cnt=%0d mmio=%b csr=%h exp 7/0/000",
                         commit_cnt, out_is_mmio, out_rcsr_id);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h5000 + 64'(i), 32'h500 + 32'(i), 1'b0, 12'(i));
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'h5000 + 64'(i) || in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_%0d got valid=%b pc=%h ready=%b exp 1/%h/1",
                           i, out_valid, out_pc, in_ready, 64'h5000 + 64'(i));
      end
    end
    drive(1'b0, 64'h0, 32'h0, 1'b0, 12'h0);
    step();
    checks++;
    if (out_valid !== 1'b0 || commit_cnt !== 64'd10) begin
      errors++; $display("FAIL b2b_drain got valid=%b cnt=%0d exp 0/10", out_valid, commit_cnt);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h3000 + 64'(4 * i), 32'h300 + 32'(i), 1'b0, 12'h0);
      step();
    end
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h3000) begin
      errors++; $display("FAIL mid_pre got valid=%b pc=%h exp 1/3000", out_valid, out_pc);
    end
    reset = 1'b1;
    drive(1'b1, 64'hDEAD, 32'hDEAD, 1'b1, 12'hDEA);
    step();
    reset = 1'b0;
    drive(1'b0, 64'h0, 32'h0, 1'b0, 12'h0);
    checks++;
    if (out_valid !== 1'b0 || commit_cnt !== 64'd0 || in_ready !== 1'b1 || out_pc !== 64'h0) begin
      errors++; $display("FAIL mid_reset got valid=%b cnt=%0d ready=%b pc=%h exp 0/0/1/0",
                         out_valid, commit_cnt, in_ready, out_pc);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || commit_cnt !== 64'd0) begin
        errors++; $display("FAIL mid_no_replay_%0d got valid=%b cnt=%0d exp 0/0", i, out_valid, commit_cnt);
      end
    end
  endtask

  task automatic test_watchdog();
    out_ready = 1'b1;
    do_reset();
`ifdef COMMIT_WATCHDOG_EN
    repeat (15) step();
    checks++;
    if (hang !== 1'b0) begin errors++; $display("FAIL wdog_early got=%b exp=0", hang); end
    step();
    checks++;
    if (hang !== 1'b1) begin errors++; $display("FAIL wdog_fire got=%b exp=1", hang); end
    drive(1'b1, 64'h4000, 32'h13, 1'b0, 12'h0);
    step();
    drive(1'b0, 64'h0, 32'h0, 1'b0, 12'h0);
    step();
    checks++;
    if (hang !== 1'b1 || commit_cnt !== 64'd1) begin
      errors++; $display("FAIL wdog_sticky got hang=%b cnt=%0d exp 1/1", hang, commit_cnt);
    end
`else
    repeat (24) step();
    checks++;
    if (hang !== 1'b0) begin errors++; $display("FAIL wdog_disabled got=%b exp=0", hang); end
`endif
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 64'h0, 32'h0, 1'b0, 12'h0);
    step();
    step();
    test_reset();
    test_single();
    test_fill_and_full_pop();
    test_mmio_csr();
    test_back_to_back();
    test_reset_mid();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
